ram_read_controller: RTL and testbench
======================================

Name: ram_read_controller

Overview:
- Reads one frame of consecutive words out of the single-port RAM and streams it to the data checker.
- Sits directly upstream of the checker. It drives the checker's start, data-valid and data inputs.
- Times the checker start pulse so the checker's internal reference generator lines up word-for-word with the streamed RAM data.
- Absorbs a configurable RAM read latency and reports when the frame has fully drained.

Parameters:
- DATA_W, 32, RAM data width.
- ADDR_W, 6, RAM address width.
- FRAME_LEN, 64, words per frame (1..2^ADDR_W).
- BASE_ADDR, 0, address of first frame word.
- RD_LAT, 1, RAM read latency in clocks from rd_en to rdata (1..4).

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_start  in  1  pulse: begin reading a frame (honoured only in IDLE).
- i_abort  in  1  synchronous abort of the current frame.
- i_ram_rdata  in  DATA_W  RAM read data.
- o_ram_rd_en  out  1  RAM read enable.
- o_ram_addr  out  ADDR_W  RAM read address.
- o_chk_start  out  1  one-cycle start pulse to the checker.
- o_data_valid  out  1  word valid to the checker.
- o_data  out  DATA_W  word to the checker.
- o_busy  out  1  frame in progress.
- o_read_done  out  1  one-cycle pulse when the frame has fully drained.

Behaviour:
- Reset:
  - One clock, i_clk. Reset i_rst is asynchronous and active-high.
  - During reset, all outputs are 0, the state is IDLE, and all counters and pipeline registers are cleared.
  - Reset mid-frame aborts immediately. No done pulse is generated.
- Timing reference: call the cycle in which i_start is sampled high "cycle 0".
- State machine:
  - IDLE -> READ on i_start.
  - READ -> DRAIN after the FRAME_LEN-th read is issued.
  - DRAIN -> DONE when the valid pipeline is empty.
  - DONE -> IDLE after one cycle.
- READ state:
  - o_ram_rd_en is high for exactly FRAME_LEN consecutive cycles, cycles 1..FRAME_LEN.
  - o_ram_addr = BASE_ADDR + k on the k-th read (k = 0..FRAME_LEN-1), computed modulo 2^ADDR_W, so it wraps past the top address.
  - o_ram_addr holds its last value when rd_en is low.
  - Word counter width: clog2(FRAME_LEN+1).
- Valid pipeline:
  - rd_en is delayed by RD_LAT through a shift register. The result marks the cycle in which i_ram_rdata is valid.
  - That word is then registered into o_data, with o_data_valid asserted alongside it.
  - Read issued in cycle c therefore appears on o_data/o_data_valid in cycle c+RD_LAT+1.
  - o_data_valid is high for cycles RD_LAT+2 .. FRAME_LEN+RD_LAT+1, contiguous with no gaps.
  - o_data holds its last value when not valid.
- o_chk_start:
  - High for exactly one cycle, coincident with the first o_data_valid (cycle RD_LAT+2).
  - This alignment is mandatory: the checker's reference generator has 1-clk latency and the checker delays incoming data by 1 clk, so the first word must be present in the start cycle.
- o_read_done:
  - One-cycle pulse in DONE, at cycle FRAME_LEN+RD_LAT+2, i.e. the cycle after the last valid word.
- o_busy:
  - High from cycle 1 through the DONE cycle inclusive.
  - Low in IDLE.
- i_start while not in IDLE is ignored; no queueing.
- i_start and i_abort sampled high together in IDLE: abort wins and the state stays IDLE.
- i_abort in READ/DRAIN/DONE:
  - Next cycle: state = IDLE, rd_en = 0, valid pipeline flushed, o_data_valid = 0, o_busy = 0.
  - No o_read_done pulse and no o_chk_start pulse (if not yet issued).
- FRAME_LEN = 1:
  - A single read.
  - o_chk_start and the only o_data_valid fall in the same cycle.
  - o_read_done follows on the next cycle.
- Back-to-back frames: an i_start sampled in the cycle after DONE (state IDLE) starts a new frame with identical timing.

Test Plan:
- Nominal frame, defaults (FRAME_LEN=64, RD_LAT=1), RAM preloaded with the generator sequence, i_start at cycle 0:
  - rd_en in cycles 1..64, addresses 0..63.
  - o_chk_start at cycle 3; o_data_valid in cycles 3..66.
  - o_read_done at cycle 67.
  - Downstream checker raises o_valid_frame.
- RD_LAT=3, FRAME_LEN=8, BASE_ADDR=60, ADDR_W=6:
  - Addresses 60,61,62,63,0,1,2,3.
  - o_chk_start and first valid at cycle 5; valid in cycles 5..12.
  - o_read_done at cycle 13.
- i_abort sampled at cycle 10 of a default frame:
  - From cycle 11 rd_en=0, o_data_valid=0, o_busy=0.
  - No o_read_done.
  - A fresh i_start at cycle 20 yields first valid at cycle 23.
- i_rst asserted asynchronously mid-READ (between edges):
  - All outputs are 0 immediately, without waiting for an edge.
  - After release, i_start produces a full, correctly timed frame.
- i_start pulses in cycles 5 and 40 during a busy frame: ignored; exactly 64 valid words and one o_read_done.
- FRAME_LEN=1, RD_LAT=1:
  - rd_en at cycle 1.
  - o_chk_start and o_data_valid at cycle 3.
  - o_read_done at cycle 4.

Source files
------------

// File: rtl/ram_read_controller.sv
// Streams one frame of consecutive RAM words to the data checker, with the checker start pulse aligned to the first word.
// A read issued in cycle c reaches o_data in cycle c+RD_LAT+1. There is no backpressure: the frame runs to completion unless aborted.
module ram_read_controller #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 6,
    parameter int FRAME_LEN = 64,
    parameter int BASE_ADDR = 0,
    parameter int RD_LAT    = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [DATA_W-1:0] i_ram_rdata,
    output logic              o_ram_rd_en,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic              o_chk_start,
    output logic              o_data_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_busy,
    output logic              o_read_done
);
    localparam int CNT_W = $clog2(FRAME_LEN + 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t              state_q, state_d;
    logic                rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [RD_LAT-1:0]   pipe_q, pipe_d;
    logic                dvld_q, dvld_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                chk_start_q, chk_start_d;
    logic                started_q, started_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                rdata_vld;

    assign rdata_vld = pipe_q[RD_LAT-1];

    always_comb begin
        state_d     = state_q;
        rd_en_d     = 1'b0;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        pipe_d      = RD_LAT'({pipe_q, rd_en_q});
        dvld_d      = rdata_vld;
        data_d      = rdata_vld ? i_ram_rdata : data_q;
        // The checker expects its start pulse in the same cycle as the first word.
        chk_start_d = rdata_vld & ~started_q;
        started_d   = started_q | rdata_vld;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                busy_d    = 1'b0;
                started_d = 1'b0;
                if (i_start && !i_abort) begin
                    state_d = READ;
                    rd_en_d = 1'b1;
                    addr_d  = ADDR_W'(BASE_ADDR);
                    cnt_d   = CNT_W'(1);
                    busy_d  = 1'b1;
                end
            end
            READ: begin
                if (cnt_q == CNT_W'(FRAME_LEN)) begin
                    state_d = DRAIN;
                end else begin
                    rd_en_d = 1'b1;
                    addr_d  = addr_q + ADDR_W'(1);
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            DRAIN: begin
                // Once no read is in flight the last word is on o_data this cycle.
                if (pipe_q == '0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (i_abort && state_q != IDLE) begin
            state_d     = IDLE;
            rd_en_d     = 1'b0;
            pipe_d      = '0;
            dvld_d      = 1'b0;
            data_d      = data_q;
            chk_start_d = 1'b0;
            started_d   = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            rd_en_q     <= 1'b0;
            addr_q      <= '0;
            cnt_q       <= '0;
            pipe_q      <= '0;
            dvld_q      <= 1'b0;
            data_q      <= '0;
            chk_start_q <= 1'b0;
            started_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_en_q     <= rd_en_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            pipe_q      <= pipe_d;
            dvld_q      <= dvld_d;
            data_q      <= data_d;
            chk_start_q <= chk_start_d;
            started_q   <= started_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign o_ram_rd_en  = rd_en_q;
    assign o_ram_addr   = addr_q;
    assign o_chk_start  = chk_start_q;
    assign o_data_valid = dvld_q;
    assign o_data       = data_q;
    assign o_busy       = busy_q;
    assign o_read_done  = done_q;

endmodule

// File: tb/tb_ram_read_controller.sv
// Directed bench: three parameter sets run side by side, checked against hand-computed timing tables.
module tb_ram_read_controller;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  st  = '0;
    logic [2:0]  ab  = '0;
    logic [2:0]  rd_en, chk, vld, busy, done;
    logic [5:0]  addr  [3];
    logic [31:0] dat   [3];
    logic [31:0] rdata [3];
    logic [31:0] r1a, r1b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ram_read_controller u0 (
        .i_clk(clk), .i_rst(rst), .i_start(st[0]), .i_abort(ab[0]), .i_ram_rdata(rdata[0]),
        .o_ram_rd_en(rd_en[0]), .o_ram_addr(addr[0]), .o_chk_start(chk[0]),
        .o_data_valid(vld[0]), .o_data(dat[0]), .o_busy(busy[0]), .o_read_done(done[0]));

    ram_read_controller #(.FRAME_LEN(8), .BASE_ADDR(60), .RD_LAT(3)) u1 (
        .i_clk(clk), .i_rst(rst), .i_start(st[1]), .i_abort(ab[1]), .i_ram_rdata(rdata[1]),
        .o_ram_rd_en(rd_en[1]), .o_ram_addr(addr[1]), .o_chk_start(chk[1]),
        .o_data_valid(vld[1]), .o_data(dat[1]), .o_busy(busy[1]), .o_read_done(done[1]));

    ram_read_controller #(.FRAME_LEN(1)) u2 (
        .i_clk(clk), .i_rst(rst), .i_start(st[2]), .i_abort(ab[2]), .i_ram_rdata(rdata[2]),
        .o_ram_rd_en(rd_en[2]), .o_ram_addr(addr[2]), .o_chk_start(chk[2]),
        .o_data_valid(vld[2]), .o_data(dat[2]), .o_busy(busy[2]), .o_read_done(done[2]));

    function automatic logic [31:0] memf(input logic [5:0] a);
        return 32'hC0DE_0000 + {26'd0, a} * 32'd7 + 32'd1;
    endfunction

    // RAM models: latency 1 for u0/u2, latency 3 for u1; idle cycles return a poison word.
    always @(posedge clk) begin
        rdata[0] <= rd_en[0] ? memf(addr[0]) : 32'hDEAD_BEEF;
        rdata[2] <= rd_en[2] ? memf(addr[2]) : 32'hDEAD_BEEF;
        r1a      <= rd_en[1] ? memf(addr[1]) : 32'hDEAD_BEEF;
        r1b      <= r1a;
        rdata[1] <= r1b;
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        int         d;
        int         c;
        logic       rd;
        logic [5:0] a;
        logic       cs;
        logic       v;
        logic       b;
        logic       dn;
    } vec_t;

    typedef struct packed {
        logic        rd;
        logic [5:0]  a;
        logic        cs;
        logic        v;
        logic        b;
        logic        dn;
        logic [31:0] dat;
    } obs_t;

    vec_t tbl[$];
    obs_t lg[3][0:89];
    int   fl[3] = '{64, 8, 1};
    int   ba[3] = '{0, 60, 0};
    int   la[3] = '{1, 3, 1};

    function automatic void add(int d, int c, logic rd, logic [5:0] a, logic cs, logic v, logic b, logic dn);
        vec_t t;
        t.d = d; t.c = c; t.rd = rd; t.a = a; t.cs = cs; t.v = v; t.b = b; t.dn = dn;
        tbl.push_back(t);
    endfunction

    initial begin
        int nv, ncs, ndn, k, fv, dc, cnt_bad;

        //      dut cyc rd addr cs vld busy done
        add(0,  0, 0,  0, 0, 0, 0, 0);
        add(0,  1, 1,  0, 0, 0, 1, 0);
        add(0,  2, 1,  1, 0, 0, 1, 0);
        add(0,  3, 1,  2, 1, 1, 1, 0);
        add(0,  4, 1,  3, 0, 1, 1, 0);
        add(0,  6, 1,  5, 0, 1, 1, 0);
        add(0, 64, 1, 63, 0, 1, 1, 0);
        add(0, 65, 0, 63, 0, 1, 1, 0);
        add(0, 66, 0, 63, 0, 1, 1, 0);
        add(0, 67, 0, 63, 0, 0, 1, 1);
        add(0, 68, 0, 63, 0, 0, 0, 0);
        add(1,  0, 0,  0, 0, 0, 0, 0);
        add(1,  1, 1, 60, 0, 0, 1, 0);
        add(1,  4, 1, 63, 0, 0, 1, 0);
        add(1,  5, 1,  0, 1, 1, 1, 0);
        add(1,  6, 1,  1, 0, 1, 1, 0);
        add(1,  8, 1,  3, 0, 1, 1, 0);
        add(1,  9, 0,  3, 0, 1, 1, 0);
        add(1, 12, 0,  3, 0, 1, 1, 0);
        add(1, 13, 0,  3, 0, 0, 1, 1);
        add(1, 14, 0,  3, 0, 0, 0, 0);
        add(2,  1, 1,  0, 0, 0, 1, 0);
        add(2,  2, 0,  0, 0, 0, 1, 0);
        add(2,  3, 0,  0, 1, 1, 1, 0);
        add(2,  4, 0,  0, 0, 0, 1, 1);
        add(2,  5, 0,  0, 0, 0, 0, 0);
        add(2,  6, 1,  0, 0, 0, 1, 0);
        add(2,  8, 0,  0, 1, 1, 1, 0);
        add(2,  9, 0,  0, 0, 0, 1, 1);
        add(2, 10, 0,  0, 0, 0, 0, 0);

        // Reset state
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset_ctl d%0d", d), {rd_en[d], chk[d], vld[d], busy[d], done[d], addr[d]}, '0);
            check($sformatf("reset_dat d%0d", d), dat[d], '0);
        end
        rst = 1'b0;

        // Main frame: u0 sees extra starts at 5 and 40 (ignored), u2 runs back-to-back frames.
        for (int c = 0; c < 90; c++) begin
            @(negedge clk);
            st[0] = (c == 0 || c == 5 || c == 40);
            st[1] = (c == 0);
            st[2] = (c == 0 || c == 5);
            for (int d = 0; d < 3; d++)
                lg[d][c] = {rd_en[d], addr[d], chk[d], vld[d], busy[d], done[d], dat[d]};
        end
        st = '0;

        foreach (tbl[i]) begin
            check($sformatf("vec d%0d c%0d {rd,addr,cs,vld,busy,done}", tbl[i].d, tbl[i].c),
                  {lg[tbl[i].d][tbl[i].c].rd, lg[tbl[i].d][tbl[i].c].a, lg[tbl[i].d][tbl[i].c].cs,
                   lg[tbl[i].d][tbl[i].c].v, lg[tbl[i].d][tbl[i].c].b, lg[tbl[i].d][tbl[i].c].dn},
                  {tbl[i].rd, tbl[i].a, tbl[i].cs, tbl[i].v, tbl[i].b, tbl[i].dn});
        end

        for (int d = 0; d < 3; d++) begin
            nv = 0; ncs = 0; ndn = 0;
            for (int c = 0; c < 90; c++) begin
                if (lg[d][c].v) begin
                    k = nv % fl[d];
                    check($sformatf("data d%0d c%0d", d, c), lg[d][c].dat, memf(6'(ba[d] + k)));
                    if (d != 2) check($sformatf("vld_cycle d%0d k%0d", d, k), c, la[d] + 2 + k);
                    nv++;
                end
                if (lg[d][c].cs) ncs++;
                if (lg[d][c].dn) ndn++;
            end
            check($sformatf("n_valid d%0d", d), nv, (d == 2) ? 2 : fl[d]);
            check($sformatf("n_chk_start d%0d", d), ncs, (d == 2) ? 2 : 1);
            check($sformatf("n_done d%0d", d), ndn, (d == 2) ? 2 : 1);
        end

        // Abort at cycle 10 on u0, restart at 20; start+abort together in IDLE on u2.
        nv = 0; ndn = 0; fv = -1; dc = -1; cnt_bad = 0;
        for (int c = 0; c < 110; c++) begin
            @(negedge clk);
            st[0] = (c == 0 || c == 20);
            st[2] = (c == 0);
            ab[2] = (c == 0);
            ab[0] = (c == 10);
            if (c == 1) check("start_abort_idle busy/rd", {busy[2], rd_en[2]}, 2'b00);
            if (c == 11) check("abort next {rd,vld,busy}", {rd_en[0], vld[0], busy[0]}, 3'b000);
            if (c >= 11 && c < 20 && (vld[0] || done[0] || chk[0] || busy[0])) cnt_bad++;
            if (c == 22) check("restart c22 vld", vld[0], 1'b0);
            if (c == 23) check("restart c23 {cs,vld}", {chk[0], vld[0]}, 2'b11);
            if (c >= 20 && vld[0]) nv++;
            if (done[0]) begin
                ndn++;
                if (dc < 0) dc = c;
            end
        end
        st = '0; ab = '0;
        check("abort quiet cycles", cnt_bad, 0);
        check("abort then restart n_done", ndn, 1);
        check("restart done cycle", dc, 87);
        check("restart n_valid", nv, 64);

        // Asynchronous reset between edges in the middle of READ.
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            st = (c == 0) ? 3'b111 : 3'b000;
        end
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("async_rst_ctl d%0d", d), {rd_en[d], chk[d], vld[d], busy[d], done[d], addr[d]}, '0);
            check($sformatf("async_rst_dat d%0d", d), dat[d], '0);
        end
        @(negedge clk);
        rst = 1'b0;

        nv = 0; ndn = 0; fv = -1; dc = -1;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            st[0] = (c == 0);
            if (vld[0]) begin
                if (fv < 0) fv = c;
                nv++;
            end
            if (done[0]) begin
                ndn++;
                if (dc < 0) dc = c;
            end
        end
        st = '0;
        check("post_rst first valid", fv, 3);
        check("post_rst n_valid", nv, 64);
        check("post_rst done cycle", dc, 67);
        check("post_rst n_done", ndn, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
